macc_operand_scheduler: RTL and testbench

MACC_OPERAND_SCHEDULER -- requirements
Module: macc_operand_scheduler

---
 rtl/macc_operand_scheduler_pkg.sv | 25 ++
 rtl/macc_operand_scheduler_if.sv | 35 +++
 rtl/macc_operand_scheduler_rr_pick2.sv | 28 ++
 rtl/macc_operand_scheduler.sv | 100 ++++++++++
 tb/tb_macc_operand_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/macc_operand_scheduler_pkg.sv
// Shared definitions for the MACC operand scheduler.
// Tokens are 32 bits wide: value in [31:16] and remaining lifetime in [15:0].
// This file holds the field widths and positions, the scheduler FSM state
// enum and a saturating increment helper for the expiry counter.
package neural_pkg;

    localparam int TOK_W     = 32;
    localparam int VAL_W_DEF = 16;
    localparam int LT_W_DEF  = 16;
    localparam int VAL_LSB   = 16;
    localparam int LT_LSB    = 0;
    localparam int CNT_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_RECIRC = 2'd2
    } sched_state_e;

    // Sticks at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/macc_operand_scheduler_if.sv
// Bus bundle between the MACC operand scheduler and its environment
// (controller, input_fifo, work_fifo).
//   op_req/op_ack/op_value : operand request handshake with the controller
//   in_*                   : input_fifo show-ahead head and pop
//   wk_*                   : work_fifo show-ahead head and pop
//   rc_*                   : recirculation push back into work_fifo
// slave  = scheduler side, master = environment side.
interface macc_operand_scheduler_if
    import neural_pkg::*;
#(
    parameter int VAL_W = VAL_W_DEF
);
    logic             op_req;
    logic             op_ack;
    logic [VAL_W-1:0] op_value;
    logic             in_empty;
    logic [TOK_W-1:0] in_data;
    logic             in_pop;
    logic             wk_empty;
    logic [TOK_W-1:0] wk_data;
    logic             wk_pop;
    logic             rc_full;
    logic             rc_push;
    logic [TOK_W-1:0] rc_data;

    modport slave (
        input  op_req, in_empty, in_data, wk_empty, wk_data, rc_full,
        output op_ack, op_value, in_pop, wk_pop, rc_push, rc_data
    );

    modport master (
        output op_req, in_empty, in_data, wk_empty, wk_data, rc_full,
        input  op_ack, op_value, in_pop, wk_pop, rc_push, rc_data
    );
endinterface

// File: rtl/macc_operand_scheduler_rr_pick2.sv
// Two-way round-robin picker.
//   clk, reset : clock and async active-low reset
//   req[1:0]   : requesters (0 = input_fifo, 1 = work_fifo)
//   adv        : the current grant was taken this cycle
//   grant[1:0] : one-hot grant (combinational)
// The pointer only moves when both requesters competed, so a lone
// requester never steals the other side's turn.
module rr_pick2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] grant
);
    logic ptr_q, ptr_d;   // 0: requester 0 has priority, 1: requester 1

    always_comb begin
        grant = req;
        if (req == 2'b11) grant = ptr_q ? 2'b10 : 2'b01;
    end

    assign ptr_d = (adv && req == 2'b11) ? ~ptr_q : ptr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ptr_q <= 1'b0;
        else        ptr_q <= ptr_d;
    end
endmodule

// File: rtl/macc_operand_scheduler.sv
// MACC operand scheduler: pulls tokens from input_fifo / work_fifo, hands
// the value to the controller, and pushes live tokens back into work_fifo
// with their lifetime decremented. Lifetime-0 tokens are dropped and
// counted.
//   clk, reset  : clock and async active-low reset
//   bus         : scheduler side of macc_operand_scheduler_if
//   busy        : state is not IDLE
//   expired_cnt : saturating count of discarded lifetime-0 tokens
// Flow: IDLE (pop + capture) -> ISSUE (op_ack or discard) -> RECIRC (push)
module macc_operand_scheduler
    import neural_pkg::*;
#(
    parameter int VAL_W = VAL_W_DEF,
    parameter int LT_W  = LT_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    macc_operand_scheduler_if.slave  bus,
    output logic                     busy,
    output logic [CNT_W-1:0]         expired_cnt
);
    sched_state_e     state_q, state_d;
    logic [TOK_W-1:0] tok_q, tok_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0]       req, grant;
    logic             take;
    logic [VAL_W-1:0] val_q;
    logic [LT_W-1:0]  lt_q, lt_dec;
    logic             lt_zero, lt_one;

    assign val_q   = tok_q[VAL_LSB +: VAL_W];
    assign lt_q    = tok_q[LT_LSB +: LT_W];
    assign lt_dec  = lt_q - LT_W'(1);   // only used when lt_q >= 2
    assign lt_zero = (lt_q == '0);
    assign lt_one  = (lt_q == LT_W'(1));

    assign req = {~bus.wk_empty, ~bus.in_empty};

    // reset is folded in so the pops stay low while reset is held, even if
    // the controller keeps op_req high.
    assign take = reset && (state_q == ST_IDLE) && bus.op_req && (|req);

    rr_pick2 u_rr (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .adv   (take),
        .grant (grant)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            tok_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tok_q   <= tok_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (take) state_d = ST_ISSUE;
            ST_ISSUE:  state_d = (lt_zero || lt_one) ? ST_IDLE : ST_RECIRC;
            ST_RECIRC: if (!bus.rc_full) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Capture and expiry count
    always_comb begin
        tok_d = tok_q;
        if (take) tok_d = grant[1] ? bus.wk_data : bus.in_data;
        cnt_d = cnt_q;
        if (state_q == ST_ISSUE && lt_zero) cnt_d = sat_inc(cnt_q);
    end

    // Outputs; everything here decodes from reset-cleared registers, so the
    // outputs drop to zero as soon as reset asserts.
    always_comb begin
        bus.op_ack   = (state_q == ST_ISSUE) && !lt_zero;
        bus.op_value = bus.op_ack ? val_q : '0;
        bus.in_pop   = take && grant[0];
        bus.wk_pop   = take && grant[1];
        bus.rc_push  = (state_q == ST_RECIRC) && !bus.rc_full;
        bus.rc_data  = '0;
        if (state_q == ST_RECIRC) begin
            bus.rc_data[VAL_LSB +: VAL_W] = val_q;
            bus.rc_data[LT_LSB +: LT_W]   = lt_dec;
        end
        busy         = (state_q != ST_IDLE);
        expired_cnt  = cnt_q;
    end
endmodule

// File: tb/tb_macc_operand_scheduler.sv
// Bench for macc_operand_scheduler. The two FIFOs are queues in the bench;
// expected operand order comes from a transaction-level model that replays
// the arbitration/recirculation rules on copies of the queues.
module tb_macc_operand_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic        busy;
    logic [15:0] expired_cnt;

    macc_operand_scheduler_if #(.VAL_W(16)) sif ();

    macc_operand_scheduler #(.VAL_W(16), .LT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (sif),
        .busy        (busy),
        .expired_cnt (expired_cnt)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] in_q[$], wk_q[$];
    logic [15:0] ack_q[$], exp_ack[$];
    int          exp_cnt;
    logic        rcf;
    logic        s_ack, s_inpop, s_wkpop, s_push, s_busy;
    logic [15:0] s_val;
    logic [31:0] s_rcdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        sif.in_empty = (in_q.size() == 0);
        sif.in_data  = (in_q.size() != 0) ? in_q[0] : 32'h0;
        sif.wk_empty = (wk_q.size() == 0);
        sif.wk_data  = (wk_q.size() != 0) ? wk_q[0] : 32'h0;
        sif.rc_full  = rcf;
    endtask

    // One clock: sample mid-cycle, then apply FIFO effects just after the edge.
    task automatic cyc();
        drive();
        @(negedge clk);
        s_ack    = sif.op_ack;
        s_val    = sif.op_value;
        s_inpop  = sif.in_pop;
        s_wkpop  = sif.wk_pop;
        s_push   = sif.rc_push;
        s_rcdata = sif.rc_data;
        s_busy   = busy;
        chk("pop_excl", 32'(s_inpop & s_wkpop), 32'd0);
        chk("pop_outside_idle", 32'((s_inpop | s_wkpop) & s_busy), 32'd0);
        @(posedge clk);
        #1;
        if (s_inpop) begin
            chk("in_pop_nonempty", 32'(in_q.size() != 0), 32'd1);
            if (in_q.size() != 0) void'(in_q.pop_front());
        end
        if (s_wkpop) begin
            chk("wk_pop_nonempty", 32'(wk_q.size() != 0), 32'd1);
            if (wk_q.size() != 0) void'(wk_q.pop_front());
        end
        if (s_push) wk_q.push_back(s_rcdata);
        if (s_ack) ack_q.push_back(s_val);
        drive();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        sif.op_req = 1'b0;
        rcf = 1'b0;
        in_q.delete();
        wk_q.delete();
        ack_q.delete();
        drive();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_op_ack"},   32'(sif.op_ack),   32'd0);
        chk({tag, "_op_value"}, 32'(sif.op_value), 32'd0);
        chk({tag, "_in_pop"},   32'(sif.in_pop),   32'd0);
        chk({tag, "_wk_pop"},   32'(sif.wk_pop),   32'd0);
        chk({tag, "_rc_push"},  32'(sif.rc_push),  32'd0);
        chk({tag, "_rc_data"},  sif.rc_data,       32'd0);
        chk({tag, "_busy"},     32'(busy),         32'd0);
        chk({tag, "_exp_cnt"},  32'(expired_cnt),  32'd0);
    endtask

    // Serial transaction model: one token at a time, 1-bit round-robin
    // pointer that moves only when both sources are non-empty.
    task automatic model(input logic [31:0] mi_in[$], input logic [31:0] mw_in[$]);
        logic [31:0] mi[$], mw[$];
        logic [31:0] t;
        bit ptr, use_wk;
        mi = mi_in;
        mw = mw_in;
        exp_ack.delete();
        exp_cnt = 0;
        ptr = 1'b0;
        while (mi.size() != 0 || mw.size() != 0) begin
            if (mi.size() != 0 && mw.size() != 0) begin
                use_wk = ptr;
                ptr = ~ptr;
            end else begin
                use_wk = (mw.size() != 0);
            end
            t = use_wk ? mw.pop_front() : mi.pop_front();
            if (t[15:0] == 16'd0) exp_cnt++;
            else begin
                exp_ack.push_back(t[31:16]);
                if (t[15:0] > 16'd1) mw.push_back({t[31:16], t[15:0] - 16'd1});
            end
        end
    endtask

    initial begin
        logic [15:0] e3[4];
        reset = 1'b0;
        sif.op_req = 1'b0;
        rcf = 1'b0;
        drive();
        #12;
        check_zero("rst");

        // Live token, lifetime 2: op_req seen at edge 1, op_ack high in the
        // cycle ending at edge 2, then recirculation with lifetime 1.
        do_reset();
        in_q.push_back(32'h0004_0002);
        sif.op_req = 1'b1;
        cyc();
        chk("t1_in_pop", 32'(s_inpop), 32'd1);
        chk("t1_no_early_ack", 32'(s_ack), 32'd0);
        sif.op_req = 1'b0;
        cyc();
        chk("t1_ack", 32'(s_ack), 32'd1);
        chk("t1_value", 32'(s_val), 32'd4);
        cyc();
        chk("t1_rc_push", 32'(s_push), 32'd1);
        chk("t1_rc_data", s_rcdata, 32'h0004_0001);
        chk("t1_ack_once", 32'(s_ack), 32'd0);
        cyc();
        chk("t1_idle", 32'(s_busy), 32'd0);
        chk("t1_wk_level", 32'(wk_q.size()), 32'd1);

        // Lifetime 1: issued, not recirculated.
        do_reset();
        in_q.push_back(32'h0005_0001);
        sif.op_req = 1'b1;
        cyc();
        sif.op_req = 1'b0;
        cyc();
        chk("t2_ack", 32'(s_ack), 32'd1);
        chk("t2_value", 32'(s_val), 32'd5);
        cyc();
        chk("t2_busy_low", 32'(s_busy), 32'd0);
        chk("t2_no_push", 32'(s_push), 32'd0);
        chk("t2_wk_empty", 32'(wk_q.size()), 32'd0);

        // Both sources non-empty: 1, 2, 1, 2.
        do_reset();
        in_q.push_back(32'h0001_0003);
        wk_q.push_back(32'h0002_0003);
        sif.op_req = 1'b1;
        for (int i = 0; i < 60 && ack_q.size() < 4; i++) cyc();
        sif.op_req = 1'b0;
        repeat (2) cyc();
        chk("t3_count", 32'(ack_q.size()), 32'd4);
        e3 = '{16'd1, 16'd2, 16'd1, 16'd2};
        for (int k = 0; k < 4 && k < ack_q.size(); k++) chk("t3_value", 32'(ack_q[k]), 32'(e3[k]));

        // A lone work grant must not move the pointer: input still wins next.
        do_reset();
        wk_q.push_back(32'h000A_0001);
        sif.op_req = 1'b1;
        cyc();
        chk("t4_wk_pop", 32'(s_wkpop), 32'd1);
        sif.op_req = 1'b0;
        cyc();
        in_q.push_back(32'h000B_0001);
        wk_q.push_back(32'h000C_0001);
        ack_q.delete();
        sif.op_req = 1'b1;
        for (int i = 0; i < 30 && ack_q.size() < 2; i++) cyc();
        sif.op_req = 1'b0;
        chk("t4_count", 32'(ack_q.size()), 32'd2);
        if (ack_q.size() >= 2) begin
            chk("t4_first", 32'(ack_q[0]), 32'h000B);
            chk("t4_second", 32'(ack_q[1]), 32'h000C);
        end

        // Expired tokens: one, then saturation of the counter.
        do_reset();
        in_q.push_back(32'h0007_0000);
        sif.op_req = 1'b1;
        cyc();
        sif.op_req = 1'b0;
        cyc();
        chk("t5_no_ack", 32'(s_ack), 32'd0);
        cyc();
        chk("t5_cnt1", 32'(expired_cnt), 32'd1);
        chk("t5_idle", 32'(s_busy), 32'd0);
        sif.op_req = 1'b1;
        // Each expired token takes exactly two cycles with op_req held.
        for (int i = 1; i <= 2 * 65540; i++) begin
            if (in_q.size() == 0) in_q.push_back(32'h0007_0000);
            cyc();
            chk("t5_sat_no_ack", 32'(s_ack), 32'd0);
            if (i == 2000)      chk("t5_cnt_1001", 32'(expired_cnt), 32'd1001);
            if (i == 2 * 65533) chk("t5_cnt_fffe", 32'(expired_cnt), 32'h0000_FFFE);
            if (i == 2 * 65534) chk("t5_cnt_ffff", 32'(expired_cnt), 32'h0000_FFFF);
        end
        sif.op_req = 1'b0;
        repeat (2) cyc();
        chk("t5_cnt_held", 32'(expired_cnt), 32'h0000_FFFF);

        // Back-pressure on recirculation for three cycles.
        do_reset();
        in_q.push_back(32'h0009_0002);
        in_q.push_back(32'h0008_0001);
        rcf = 1'b1;
        sif.op_req = 1'b1;
        cyc();
        cyc();
        chk("t6_ack", 32'(s_ack), 32'd1);
        chk("t6_value", 32'(s_val), 32'd9);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t6_stall_push", 32'(s_push), 32'd0);
            chk("t6_stall_pops", 32'(s_inpop | s_wkpop), 32'd0);
            chk("t6_stall_data", s_rcdata, 32'h0009_0001);
        end
        rcf = 1'b0;
        cyc();
        sif.op_req = 1'b0;
        chk("t6_push", 32'(s_push), 32'd1);
        chk("t6_push_data", s_rcdata, 32'h0009_0001);
        chk("t6_in_left", 32'(in_q.size()), 32'd1);
        cyc();

        // Reset while stalled in RECIRC: outputs clear without a clock edge.
        do_reset();
        in_q.push_back(32'h0003_0005);
        in_q.push_back(32'h0006_0001);
        rcf = 1'b1;
        sif.op_req = 1'b1;
        cyc();
        cyc();
        cyc();
        chk("t7_in_recirc", 32'(s_busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        check_zero("t7_async");
        @(posedge clk);
        #1;
        reset = 1'b1;
        rcf = 1'b0;
        sif.op_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t7_no_push", 32'(s_push), 32'd0);
            chk("t7_idle", 32'(s_busy), 32'd0);
        end
        chk("t7_wk_empty", 32'(wk_q.size()), 32'd0);

        // Random tokens in both FIFOs, random back-pressure.
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int k = 0; k < 8; k++) begin
                in_q.push_back({16'($urandom), 16'($urandom_range(0, 3))});
                wk_q.push_back({16'($urandom), 16'($urandom_range(0, 3))});
            end
            model(in_q, wk_q);
            sif.op_req = 1'b1;
            for (int c = 0; c < 4000; c++) begin
                rcf = ($urandom_range(0, 2) == 0);
                cyc();
                if (in_q.size() == 0 && wk_q.size() == 0 && !busy) break;
            end
            sif.op_req = 1'b0;
            rcf = 1'b0;
            chk("rnd_drained", 32'(in_q.size() == 0 && wk_q.size() == 0 && !busy), 32'd1);
            chk("rnd_ack_count", 32'(ack_q.size()), 32'(exp_ack.size()));
            for (int k = 0; k < ack_q.size() && k < exp_ack.size(); k++)
                chk("rnd_value", 32'(ack_q[k]), 32'(exp_ack[k]));
            chk("rnd_expired", 32'(expired_cnt), 32'(exp_cnt));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
